// File: rtl/calc_alu_if.sv
// calc_alu_if: start/done handshake plus operand and result bus between the sequencer and the shared ALU.
interface calc_alu_if #(parameter int W = 40);
  logic alu_start, alu_sign, alu_err, alu_done;
  logic [1:0] alu_op;
  logic [W-1:0] S1, S2, alu_result;
  modport master(output alu_start, alu_op, S1, S2, input alu_result, alu_sign, alu_err, alu_done);
  modport slave(input alu_start, alu_op, S1, S2, output alu_result, alu_sign, alu_err, alu_done);
endinterface

// File: rtl/calc_alu_sequencer.sv
// calc_alu_sequencer: captures two keypad operands, runs one ALU op per start/done handshake, latches the result.
// Optional CALC_TIMEOUT_EN aborts EXEC to the error state after TIMEOUT_CYCLES cycles without alu_done.
module calc_alu_sequencer #(
  parameter int W = 40,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset_button,
  input  logic             enter_pulse,
  input  logic             enable_switch,
  input  logic [1:0]       op_sel,
  input  logic [W-1:0]     in_val,
  calc_alu_if.master       alu,
  output logic [W-1:0]     result,
  output logic             o_sign,
  output logic [1:0]       display_sel,
  output logic [3:0]       led,
  output logic             busy
);
  typedef enum logic [2:0] {ST_A, ST_B, ST_EXEC, ST_SHOW, ST_ERR} state_t;
  state_t state;
  logic chain;
  logic go;
  assign go = enter_pulse & enable_switch;
`ifdef CALC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif
  always_ff @(posedge clk or posedge reset_button)
    if (reset_button) begin
      state <= ST_A;
      chain <= 1'b0;
      alu.S1 <= '0;
      alu.S2 <= '0;
      alu.alu_op <= 2'b00;
      alu.alu_start <= 1'b0;
      result <= '0;
      o_sign <= 1'b0;
      display_sel <= 2'b00;
      led <= 4'b0000;
      busy <= 1'b0;
`ifdef CALC_TIMEOUT_EN
      cnt <= '0;
`endif
    end else begin
      alu.alu_start <= 1'b0;
      case (state)
        ST_A: begin
          display_sel <= 2'b00;
          led <= 4'b0001;
          if (go) begin
            alu.S1 <= in_val;
            state <= ST_B;
            display_sel <= 2'b01;
            led <= 4'b0010;
          end
        end
        ST_B: if (go) begin
          alu.S2 <= in_val;
          alu.alu_op <= op_sel;
          alu.alu_start <= 1'b1;
          state <= ST_EXEC;
          display_sel <= 2'b10;
          led <= 4'b0100;
          busy <= 1'b1;
`ifdef CALC_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        ST_EXEC:
          // a done coincident with our own start strobe cannot belong to this op
          if (alu.alu_done && !alu.alu_start) begin
            result <= alu.alu_err ? '0 : alu.alu_result;
            o_sign <= alu.alu_err ? 1'b0 : alu.alu_sign;
            state <= alu.alu_err ? ST_ERR : ST_SHOW;
            led <= alu.alu_err ? 4'b1111 : 4'b0100;
            chain <= alu.alu_err ? 1'b0 : chain;
            display_sel <= 2'b11;
            busy <= 1'b0;
          end
`ifdef CALC_TIMEOUT_EN
          else if (cnt == LAST) begin
            result <= '0;
            o_sign <= 1'b0;
            state <= ST_ERR;
            led <= 4'b1110;
            chain <= 1'b0;
            display_sel <= 2'b11;
            busy <= 1'b0;
          end else cnt <= cnt + 1'b1;
`endif
        ST_SHOW: if (go) begin
          alu.S1 <= result;
          chain <= 1'b1;
          state <= ST_B;
          display_sel <= 2'b01;
          led <= 4'b1000;
        end
        ST_ERR: if (go) begin
          alu.S1 <= '0;
          alu.S2 <= '0;
          chain <= 1'b0;
          state <= ST_A;
          display_sel <= 2'b00;
          led <= 4'b0001;
        end
        default: state <= ST_A;
      endcase
    end
endmodule
